mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer in front of the memory controller FSM.
//  Latches one request, then drives the controller's cs/wr_enb/rd_enb activate-then-command
//  sequence and waits for the controller's write_enb/read_enb strobe.
//  Returns done (plus read data) to the granted requester; shares a single memory port.
// PARAMETERS
//  ADDR_W       8  address width
//  DATA_W       8  data width
//  TIMEOUT_CYC  8  max WAIT cycles before abort (only with MEMARB_TIMEOUT_EN)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  req0/req1  in   1       request, level; held until matching done
//  we0/we1    in   1       1=write, 0=read
//  addr0/1    in   ADDR_W  request address
//  wdata0/1   in   DATA_W  write data
//  gnt0/gnt1  out  1       grant, high from ACT through DONE
//  done0/1    out  1       one-cycle completion pulse
//  rdata      out  DATA_W  read data, valid with done of a read
//  err        out  1       timeout flag, pulses with done
//  cs, wr_enb, rd_enb  out  1       to controller
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched write data
//  write_enb, read_enb  in  1       strobes from controller
//  mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0; all outputs 0 (gnt, done, err, cs, wr_enb, rd_enb, rdata, mem_*).
//  - Outputs decode from registered state/latches only; no input-to-output comb path.
//  - FSM: IDLE -> ACT -> CMD -> WAIT -> DONE -> IDLE.
//    IDLE: on any req at clk edge, pick winner, latch id/we/addr/wdata, go ACT.
//    ACT:  cs=1, wr_enb=0, rd_enb=0 (one cycle; controller moves to its activate state).
//    CMD:  cs=1, wr_enb=we, rd_enb=~we (one cycle).
//    WAIT: cs=0; leave on write_enb|read_enb; on read_enb capture mem_rdata into rdata.
//    DONE: done[id]=1 one cycle; ptr <= ~id; go IDLE.
//  - Latency: req sampled at edge N -> ACT N+1, CMD N+2, WAIT N+3, done at N+4.
//    Back-to-back: next grant sampled in the IDLE cycle after DONE (5-cycle period).
//  - Arbitration: both req in IDLE -> requester ptr wins; single req wins regardless of ptr.
//  - req drop after grant: ignored; transaction completes on latched values.
//  - Strobe mismatch (read_enb on a write or vice versa) is still treated as completion.
//  - rdata holds last captured read value until next read capture or reset.
//  - Reset mid-operation: immediate return to IDLE, all outputs 0, ptr=0; no done issued.
// CONFIGURATION
//  MEMARB_TIMEOUT_EN defined: counter ($clog2(TIMEOUT_CYC+1) bits) clears on WAIT entry,
//    increments each WAIT cycle; after TIMEOUT_CYC WAIT cycles with no strobe -> DONE
//    with err=1 alongside done; rdata unchanged; ptr still advances.
//  Not defined: WAIT waits indefinitely; err tied 0; no counter logic.
// TESTING
//  reset: rst=1 mid-CMD -> next cycle all outputs 0, state IDLE; after release req1 wins first.
//  req0 write addr=8'h10 wdata=8'hA5 -> cs/wr_enb seq at N+1/N+2, gnt0 N+1..N+4, done0 at N+4.
//  req1 read addr=8'h22, mem_rdata=8'h3C on read_enb -> done1 at N+4, rdata=8'h3C.
//  req0 & req1 held together, ptr=0 -> serviced 0,1,0,1; each done 5 cycles apart.
//  MEMARB_TIMEOUT_EN, no strobe -> done0 & err=1 at WAIT entry + 8 cycles; without macro, gnt0 held.
//  req0 dropped in ACT -> transaction still completes, done0 pulses once.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Requester, controller-command and controller-strobe signals of mem_req_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              cs;
    logic              wr_enb;
    logic              rd_enb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              write_enb;
    logic              read_enb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  write_enb, read_enb, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, err,
        output cs, wr_enb, rd_enb, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output write_enb, read_enb, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, err,
        input  cs, wr_enb, rd_enb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the memory controller.
// Define MEMARB_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT_CYC cycles (err=1).
module mem_req_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 8
) (
    input logic              clk,
    input logic              rst,
    mem_req_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACT  = 3'd1;
    localparam logic [2:0] S_CMD  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state;
    logic              ptr;
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              win;
    logic              any_req;
    logic              strobe;
    logic              timed_out;
    logic              busy;

    // ptr only matters on a tie; a lone requester always wins
    assign any_req = bus.req0 | bus.req1;
    assign win     = (bus.req0 & bus.req1) ? ptr : bus.req1;
    assign strobe  = bus.write_enb | bus.read_enb;

`ifdef MEMARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_CMD) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_CMD) begin
            err_q <= 1'b0;
        end else if (state == S_WAIT && !strobe && timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = (state == S_DONE) & err_q;
`else
    assign timed_out = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= 1'b0;
            id      <= 1'b0;
            we      <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        id      <= win;
                        we      <= win ? bus.we1 : bus.we0;
                        addr_q  <= win ? bus.addr1 : bus.addr0;
                        wdata_q <= win ? bus.wdata1 : bus.wdata0;
                        state   <= S_ACT;
                    end
                end
                S_ACT:  state <= S_CMD;
                S_CMD:  state <= S_WAIT;
                S_WAIT: begin
                    // either strobe completes, even if it mismatches the command
                    if (strobe) begin
                        if (bus.read_enb) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        state <= S_DONE;
                    end else if (timed_out) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr   <= ~id;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_ACT) | (state == S_CMD) |
                  (state == S_WAIT) | (state == S_DONE);

    assign bus.gnt0      = busy & ~id;
    assign bus.gnt1      = busy & id;
    assign bus.done0     = (state == S_DONE) & ~id;
    assign bus.done1     = (state == S_DONE) & id;
    assign bus.cs        = (state == S_ACT) | (state == S_CMD);
    assign bus.wr_enb    = (state == S_CMD) & we;
    assign bus.rd_enb    = (state == S_CMD) & ~we;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small controller model that
// answers each command with a strobe in the first WAIT cycle.
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic strobe_en = 1'b1;
    logic pend_w = 1'b0;
    logic pend_r = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mem_req_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_req_arbiter #(
        .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // controller: sees CMD at one negedge, strobes from the next one (mid-WAIT)
    always @(negedge clk) begin
        bus.write_enb = pend_w;
        bus.read_enb  = pend_r;
        pend_w = strobe_en && bus.cs && bus.wr_enb;
        pend_r = strobe_en && bus.cs && bus.rd_enb;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {gnt0,gnt1,cs,wr_enb,rd_enb,done0,done1,err}
    function automatic logic [7:0] sig();
        return {bus.gnt0, bus.gnt1, bus.cs, bus.wr_enb,
                bus.rd_enb, bus.done0, bus.done1, bus.err};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        bus.req0 = 0; bus.req1 = 0;
        bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0;
        bus.mem_rdata = 0;
        tick(); tick();
        check("rst_sig", 32'(sig()), 32'h00);
        check("rst_rdata", 32'(bus.rdata), 32'h00);
        check("rst_maddr", 32'(bus.mem_addr), 32'h00);
        check("rst_mwdata", 32'(bus.mem_wdata), 32'h00);
        rst = 0;
        tick();

        // write from requester 0
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        tick();
        check("w_act", 32'(sig()), 32'hA0);
        check("w_maddr", 32'(bus.mem_addr), 32'h10);
        check("w_mwdata", 32'(bus.mem_wdata), 32'hA5);
        tick();
        check("w_cmd", 32'(sig()), 32'hB0);
        tick();
        check("w_wait", 32'(sig()), 32'h80);
        tick();
        check("w_done", 32'(sig()), 32'h84);
        bus.req0 = 0;
        tick();
        check("w_idle", 32'(sig()), 32'h00);

        // read from requester 1
        bus.mem_rdata = 8'h3C;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h22;
        tick();
        check("r_act", 32'(sig()), 32'h60);
        check("r_maddr", 32'(bus.mem_addr), 32'h22);
        tick();
        check("r_cmd", 32'(sig()), 32'h68);
        tick();
        check("r_wait", 32'(sig()), 32'h40);
        tick();
        check("r_done", 32'(sig()), 32'h42);
        check("r_rdata", 32'(bus.rdata), 32'h3C);
        bus.req1 = 0;
        tick();
        check("r_hold", 32'(bus.rdata), 32'h3C);

        // both held, ptr=0: 0,1,0,1 with 5-cycle spacing
        bus.mem_rdata = 8'h5A;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h30; bus.wdata0 = 8'h11;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h44;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (cyc < 10) begin
                tick();
                cyc++;
                if (bus.done0 || bus.done1) break;
            end
            check($sformatf("b2b_who%0d", k), 32'({bus.done0, bus.done1}),
                  (k % 2 == 0) ? 32'h2 : 32'h1);
            check($sformatf("b2b_gap%0d", k), 32'(cyc),
                  (k == 0) ? 32'd4 : 32'd5);
        end
        bus.req0 = 0; bus.req1 = 0;
        tick();
        check("b2b_idle", 32'(sig()), 32'h00);
        check("b2b_rdata", 32'(bus.rdata), 32'h5A);

        // req0 dropped during ACT still completes exactly once
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h55; bus.wdata0 = 8'h66;
        tick();
        check("drop_act", 32'(sig()), 32'hA0);
        bus.req0 = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done0) pulses++;
        end
        check("drop_pulses", 32'(pulses), 32'd1);
        check("drop_rdata", 32'(bus.rdata), 32'h5A);

        // no strobe from controller
        strobe_en = 0;
        bus.mem_rdata = 8'hEE;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h77;
        tick(); tick(); tick();
        check("to_wait", 32'(sig()), 32'h80);
        bus.req0 = 0;
`ifdef MEMARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        check("to_still", 32'(sig()), 32'h80);
        tick();
        check("to_done", 32'(sig()), 32'h85);
        check("to_rdata", 32'(bus.rdata), 32'h5A);
        tick();
        check("to_idle", 32'(sig()), 32'h00);
`else
        for (int i = 0; i < 12; i++) tick();
        check("to_hung", 32'(sig()), 32'h80);
        rst = 1;
        #1;
        check("to_rst", 32'(sig()), 32'h00);
        tick();
        rst = 0;
`endif
        strobe_en = 1;
        tick();

        // reset in CMD, then a lone req1 wins
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h99; bus.wdata0 = 8'h01;
        tick(); tick();
        check("mr_cmd", 32'(sig()), 32'hB0);
        rst = 1;
        #1;
        check("mr_sig", 32'(sig()), 32'h00);
        check("mr_rdata", 32'(bus.rdata), 32'h00);
        check("mr_maddr", 32'(bus.mem_addr), 32'h00);
        tick();
        check("mr_hold", 32'(sig()), 32'h00);
        rst = 0;
        bus.req0 = 0;
        bus.mem_rdata = 8'h77;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h12;
        tick();
        check("mr_act1", 32'(sig()), 32'h60);
        tick(); tick(); tick();
        check("mr_done1", 32'(sig()), 32'h42);
        check("mr_rdata1", 32'(bus.rdata), 32'h77);
        bus.req1 = 0;
        tick();
        check("mr_idle", 32'(sig()), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
